// File: rtl/fetch_buffer.sv
// fetch_buffer: in-order instruction queue between the fetch stage and IF/ID.
// It buffers fetched instructions so a decode stall back-pressures fetch
// through valid/ready instead of dropping instructions. A flush empties the
// whole queue in one cycle when a branch redirects fetch.
// Optional feature: define FETCH_BUF_PREDECODE_EN to add deq_is_ctrl, a
// per-entry flag marking branch/JAL/JALR instructions, computed at enqueue.
module fetch_buffer #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 64,
    parameter int INST_W = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  logic [PC_W-1:0]              enq_pc,
    input  logic [INST_W-1:0]            enq_inst,
    output logic                         deq_valid,
    input  logic                         deq_ready,
    output logic [PC_W-1:0]              deq_pc,
    output logic [INST_W-1:0]            deq_inst,
`ifdef FETCH_BUF_PREDECODE_EN
    output logic                         deq_is_ctrl,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [INST_W-1:0] NOP = INST_W'(32'h00000013);

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic              do_enq;
    logic              do_deq;

`ifdef FETCH_BUF_PREDECODE_EN
    logic              ctrl_mem [DEPTH];
    logic              enq_is_ctrl;
`endif

    // Handshake status and the qualified enqueue/dequeue events; flush suppresses both.
    always_comb begin
        enq_ready = (count != FULL);
        deq_valid = (count != '0);
        do_enq    = enq_valid && enq_ready && !flush;
        do_deq    = deq_valid && deq_ready && !flush;
    end

    // Head entry is presented combinationally; an empty queue shows PC 0 and a NOP.
    always_comb begin
        deq_pc   = '0;
        deq_inst = NOP;
        if (deq_valid) begin
            deq_pc   = pc_mem[head];
            deq_inst = inst_mem[head];
        end
    end

`ifdef FETCH_BUF_PREDECODE_EN
    // Control-flow predecode on the incoming word, and the head entry's stored flag.
    always_comb begin
        enq_is_ctrl = (enq_inst[6:0] == 7'b1100011) ||
                      (enq_inst[6:0] == 7'b1101111) ||
                      (enq_inst[6:0] == 7'b1100111);
        deq_is_ctrl = deq_valid ? ctrl_mem[head] : 1'b0;
    end
`endif

    // Entry storage is written at the tail; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            pc_mem[tail]   <= enq_pc;
            inst_mem[tail] <= enq_inst;
`ifdef FETCH_BUF_PREDECODE_EN
            ctrl_mem[tail] <= enq_is_ctrl;
`endif
        end
    end

    // Pointers and occupancy; flush wins over any enqueue or dequeue in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_enq) begin
                tail <= tail + 1'b1;
            end
            if (do_deq) begin
                head <= head + 1'b1;
            end
            case ({do_enq, do_deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed self-checking bench for fetch_buffer.
// Covers reset values, enqueue latency, full back-pressure, FIFO order with
// pointer wrap, flush priority, asynchronous mid-stream reset and, when
// FETCH_BUF_PREDECODE_EN is defined, the control-flow predecode flag.
module tb_fetch_buffer;

    localparam int DEPTH  = 4;
    localparam int PC_W   = 64;
    localparam int INST_W = 32;
    localparam int CNT_W  = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              enq_valid;
    logic              enq_ready;
    logic [PC_W-1:0]   enq_pc;
    logic [INST_W-1:0] enq_inst;
    logic              deq_valid;
    logic              deq_ready;
    logic [PC_W-1:0]   deq_pc;
    logic [INST_W-1:0] deq_inst;
    logic [CNT_W-1:0]  count;
`ifdef FETCH_BUF_PREDECODE_EN
    logic              deq_is_ctrl;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    fetch_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .enq_valid   (enq_valid),
        .enq_ready   (enq_ready),
        .enq_pc      (enq_pc),
        .enq_inst    (enq_inst),
        .deq_valid   (deq_valid),
        .deq_ready   (deq_ready),
        .deq_pc      (deq_pc),
        .deq_inst    (deq_inst),
`ifdef FETCH_BUF_PREDECODE_EN
        .deq_is_ctrl (deq_is_ctrl),
`endif
        .count       (count)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ev, input logic [PC_W-1:0] pc, input logic [INST_W-1:0] inst,
                                 input logic dr, input logic fl);
        enq_valid = ev;
        enq_pc    = pc;
        enq_inst  = inst;
        deq_ready = dr;
        flush     = fl;
    endtask

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        idle();
        #3;
        checkOutput("reset_deq_valid", 64'(deq_valid), 64'd0);
        checkOutput("reset_enq_ready", 64'(enq_ready), 64'd1);
        checkOutput("reset_count",     64'(count),     64'd0);
        checkOutput("reset_deq_pc",    deq_pc,         64'd0);
        checkOutput("reset_deq_inst",  64'(deq_inst),  64'h13);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Single enqueue: not visible before the edge, visible after.
        applyStimulus(1'b1, 64'h0, 32'h00500093, 1'b0, 1'b0);
        #1;
        checkOutput("pre_edge_deq_valid", 64'(deq_valid), 64'd0);
        checkOutput("pre_edge_deq_inst",  64'(deq_inst),  64'h13);
        tick();
        idle();
        #1;
        checkOutput("first_deq_valid", 64'(deq_valid), 64'd1);
        checkOutput("first_deq_pc",    deq_pc,         64'h0);
        checkOutput("first_deq_inst",  64'(deq_inst),  64'h00500093);
        checkOutput("first_count",     64'(count),     64'd1);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        idle();
        checkOutput("drain_one_count", 64'(count), 64'd0);

        // Fill to full, then show a 5th enqueue is refused, even with a dequeue in the same cycle.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 64'(i*4), 32'h100 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b1, 64'h10, 32'h999, 1'b0, 1'b0);
        #1;
        checkOutput("full_count",     64'(count),     64'd4);
        checkOutput("full_enq_ready", 64'(enq_ready), 64'd0);
        tick();
        checkOutput("full_hold_count", 64'(count), 64'd4);
        applyStimulus(1'b1, 64'h10, 32'h999, 1'b1, 1'b0);
        #1;
        checkOutput("full_nopass_ready", 64'(enq_ready), 64'd0);
        checkOutput("full_head_pc",      deq_pc,         64'h0);
        tick();
        checkOutput("full_deq_count", 64'(count), 64'd3);
        for (int i = 1; i < 4; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
            #1;
            checkOutput("drain_pc",   deq_pc,        64'(i*4));
            checkOutput("drain_inst", 64'(deq_inst), 64'h100 + 64'(i));
            tick();
        end
        idle();
        #1;
        checkOutput("drained_deq_valid", 64'(deq_valid), 64'd0);
        checkOutput("drained_count",     64'(count),     64'd0);

        // Steady state at count 2 with simultaneous enqueue and dequeue; pointers wrap.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 64'h20 + 64'(i*4), 32'h1020 + 32'(i*4), 1'b0, 1'b0);
            tick();
        end
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 64'h28 + 64'(k*4), 32'h1028 + 32'(k*4), 1'b1, 1'b0);
            #1;
            checkOutput("stream_pc",   deq_pc,        64'h20 + 64'(k*4));
            checkOutput("stream_inst", 64'(deq_inst), 64'h1020 + 64'(k*4));
            tick();
            checkOutput("stream_count", 64'(count), 64'd2);
        end
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
            #1;
            checkOutput("stream_tail_pc", deq_pc, 64'h38 + 64'(k*4));
            tick();
        end
        idle();

        // Flush with a live enqueue and dequeue: both are ignored and the queue empties.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 64'h80 + 64'(i*4), 32'h2000 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b1, 64'h8C, 32'h2003, 1'b1, 1'b1);
        #1;
        checkOutput("flush_cycle_deq_valid", 64'(deq_valid), 64'd1);
        tick();
        idle();
        #1;
        checkOutput("post_flush_count",     64'(count),     64'd0);
        checkOutput("post_flush_deq_valid", 64'(deq_valid), 64'd0);
        checkOutput("post_flush_enq_ready", 64'(enq_ready), 64'd1);
        checkOutput("post_flush_deq_pc",    deq_pc,         64'd0);
        applyStimulus(1'b1, 64'h90, 32'h3000, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        checkOutput("after_flush_pc",    deq_pc,        64'h90);
        checkOutput("after_flush_count", 64'(count),    64'd1);

        // Asynchronous reset in the middle of a clock period with three entries queued.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 64'h94 + 64'(i*4), 32'h3001 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        idle();
        #1;
        checkOutput("pre_reset_count", 64'(count), 64'd3);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("async_reset_count",     64'(count),     64'd0);
        checkOutput("async_reset_deq_valid", 64'(deq_valid), 64'd0);
        checkOutput("async_reset_deq_inst",  64'(deq_inst),  64'h13);
        @(negedge clk);
        reset = 1'b1;
        tick();

`ifdef FETCH_BUF_PREDECODE_EN
        // Predecode: BEQ is control flow, ADDI NOP is not.
        applyStimulus(1'b1, 64'h100, 32'h00000063, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 64'h104, 32'h00000013, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        checkOutput("ctrl_beq", 64'(deq_is_ctrl), 64'd1);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        idle();
        #1;
        checkOutput("ctrl_nop", 64'(deq_is_ctrl), 64'd0);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        idle();
        #1;
        checkOutput("ctrl_empty", 64'(deq_is_ctrl), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
